// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button conditioner.
// BTN_AUTOREPEAT_EN selects the auto-repeat build of btn_debounce.
package btn_pkg;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_ENTER = 4;
    localparam int N_BTN     = 5;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } rep_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, debounce counter and press/repeat pulser.
// Auto-repeat (HOLD/REPEAT) is compiled in only with BTN_AUTOREPEAT_EN.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter bit repeat_en       = 1'b1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync_q, sync_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;
    logic          rise;

    always_comb begin
        sync1_d  = raw;
        sync_d   = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        // any sample equal to the stable value restarts the count
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign rise = stable_d & ~stable_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1_q  <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    rep_state_t    state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          fall;

    assign fall = ~stable_d & stable_q;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        pulse_d = 1'b0;
        if (fall) begin
            state_d = IDLE;
            rcnt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        pulse_d = 1'b1;
                        state_d = HOLD;
                        rcnt_d  = '0;
                    end
                end
                HOLD: begin
                    // without repeat the counter parks at 0
                    if (repeat_en) begin
                        if (rcnt_q == DELAY_LAST) begin
                            pulse_d = 1'b1;
                            state_d = REPEAT;
                            rcnt_d  = '0;
                        end else begin
                            rcnt_d = rcnt_q + RW'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (rcnt_q == PERIOD_LAST) begin
                        pulse_d = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = repeat_en ^ (REPEAT_DELAY > REPEAT_PERIOD);

    always_comb begin
        pulse_d = rise;
    end
`endif

    assign level = stable_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Five-button synchronise/debounce/pulse front end for the game core.
// Define BTN_AUTOREPEAT_EN to enable auto-repeat on REPEAT_MASK buttons.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int               DEBOUNCE_CYCLES = 1000000,
    parameter int               REPEAT_DELAY    = 25000000,
    parameter int               REPEAT_PERIOD   = 10000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b01111
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic             btn_any
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .repeat_en       (REPEAT_MASK[i])
        ) u_deb (
            .CLK   (CLK),
            .RST_N (RST_N),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .pulse (btn_pulse[i])
        );
    end

    assign btn_any = |btn_pulse;

endmodule
